// File: rtl/icache_if.sv
// CPU fetch port and memory read/return port of the instruction cache.
interface icache_if;
    logic        icache_req;
    logic        icache_iscache;
    logic [3:0]  icache_offset;
    logic [7:0]  icache_index;
    logic [19:0] icache_tag;
    logic        icache_addr_ok;
    logic        icache_data_ok;
    logic [31:0] icache_rdata;
    logic        rd_req;
    logic        rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    modport slave (
        input  icache_req, icache_iscache, icache_offset, icache_index, icache_tag,
        output icache_addr_ok, icache_data_ok, icache_rdata,
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data
    );

    modport master (
        output icache_req, icache_iscache, icache_offset, icache_index, icache_tag,
        input  icache_addr_ok, icache_data_ok, icache_rdata,
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 256 lines x 16 bytes, one outstanding miss.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module icache (
    input  logic       clk,
    input  logic       reset,
    icache_if.slave    bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;

    state_t      state, next_state;
    logic        req_iscache;
    logic [3:0]  req_offset;
    logic [7:0]  req_index;
    logic [19:0] req_tag;
    logic [1:0]  beat_cnt;
    logic [31:0] resp_word;
    logic [255:0] valid;
    logic [19:0] tag_mem  [256];
    logic [31:0] data_mem [1024];
    logic        hit, addr_ok, data_ok, rd_req, last_beat;

    assign hit = (state == LOOKUP) && req_iscache && valid[req_index]
                 && (tag_mem[req_index] == req_tag);
    assign last_beat = (state == REFILL) && bus.ret_valid && bus.ret_last;

    always_comb begin
        next_state = state;
        addr_ok    = 1'b0;
        data_ok    = 1'b0;
        rd_req     = 1'b0;
        case (state)
            IDLE: begin
                addr_ok = bus.icache_req;
                if (bus.icache_req) next_state = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    data_ok    = 1'b1;
                    addr_ok    = bus.icache_req;
                    next_state = bus.icache_req ? LOOKUP : IDLE;
                end else begin
                    next_state = MISS;
                end
            end
            MISS: begin
                rd_req = 1'b1;
                if (bus.rd_rdy) next_state = REFILL;
            end
            REFILL: begin
                if (last_beat) next_state = RESP;
            end
            RESP: begin
                data_ok    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.icache_addr_ok = addr_ok;
    assign bus.icache_data_ok = data_ok;
    assign bus.rd_req         = rd_req;
    assign bus.rd_type        = req_iscache;
    assign bus.rd_addr        = req_iscache ? {req_tag, req_index, 4'b0000}
                                            : {req_tag, req_index, req_offset[3:2], 2'b00};
    assign bus.icache_rdata   = (state == RESP) ? resp_word
                                                : data_mem[{req_index, req_offset[3:2]}];

    // Control state: the only registers touched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= '0;
            beat_cnt <= 2'd0;
        end else begin
            state <= next_state;
            if (state == REFILL && bus.ret_valid) begin
                beat_cnt <= last_beat ? 2'd0 : beat_cnt + 2'd1;
            end else if (state != REFILL) begin
                beat_cnt <= 2'd0;
            end
            if (last_beat && req_iscache) valid[req_index] <= 1'b1;
        end
    end

    // Request latch, refill data and tags carry no reset.
    always_ff @(posedge clk) begin
        if (addr_ok) begin
            req_iscache <= bus.icache_iscache;
            req_offset  <= bus.icache_offset;
            req_index   <= bus.icache_index;
            req_tag     <= bus.icache_tag;
        end
        if (!reset && state == REFILL && bus.ret_valid) begin
            if (req_iscache) data_mem[{req_index, beat_cnt}] <= bus.ret_data;
            // An uncached read returns exactly the requested word as its only beat.
            if (!req_iscache || beat_cnt == req_offset[3:2]) resp_word <= bus.ret_data;
            if (bus.ret_last && req_iscache) tag_mem[req_index] <= req_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (state == LOOKUP && req_iscache) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: icache_req  in  1  fetch request valid.
REQ-004 SHALL have: icache_iscache  in  1  1=cached access, 0=uncached single-word read.
REQ-005 SHALL have: icache_offset  in  4  byte offset in line; [3:2] word select, [1:0] ignored.
REQ-006 SHALL have: icache_index  in  8  set index (256 sets).
REQ-007 SHALL have: icache_tag  in  20  physical tag; valid in the same cycle as icache_req.
REQ-008 SHALL have: icache_addr_ok  out  1  request accepted this cycle.
REQ-009 SHALL have: icache_data_ok  out  1  rdata valid this cycle.
REQ-010 SHALL have: icache_rdata  out  32  instruction word.
REQ-011 SHALL have: rd_req  out  1, rd_type  out  1 (0=word, 1=16-byte line), rd_addr  out  32, rd_rdy  in  1: memory read request handshake.
REQ-012 SHALL have: ret_valid  in  1, ret_last  in  1, ret_data  in  32: memory return beats, in address order starting at word 0.

Function
REQ-013 SHALL be direct-mapped: 256 lines x 4 words, per-line 20-bit tag and valid bit.
REQ-014 SHALL implement states IDLE, LOOKUP, MISS, REFILL, RESP.
REQ-015 SHALL assert icache_addr_ok = icache_req in IDLE, and in LOOKUP only when current lookup hits; otherwise 0.
REQ-016 SHALL latch iscache, offset, index, tag on every addr_ok; accepted request completes even if icache_req later drops.
REQ-017 On acceptance SHALL enter LOOKUP next cycle.
REQ-018 LOOKUP hit (iscache=1, valid, tag equal): data_ok=1, rdata=line word offset[3:2], same cycle; next state LOOKUP if new request accepted, else IDLE.
REQ-019 LOOKUP miss or iscache=0: data_ok=0, next state MISS.
REQ-020 MISS SHALL hold rd_req=1; cached: rd_type=1, rd_addr={tag,index,4'b0}; uncached: rd_type=0, rd_addr={tag,index,offset[3:2],2'b0}; on rd_rdy go REFILL.
REQ-021 REFILL SHALL count beats with 2-bit counter from 0; cached beats write data array word [counter]; beat with counter==offset[3:2] latched as response word.
REQ-022 On ret_valid&ret_last SHALL go RESP; cached: write tag, set valid in that cycle; uncached: no array/tag/valid update.
REQ-023 RESP SHALL assert data_ok=1 with latched word for exactly one cycle, addr_ok=0, then IDLE.
REQ-024 Beats with ret_valid=0 SHALL be ignored; REFILL holds indefinitely.
REQ-025 A request to a just-refilled line accepted after RESP SHALL hit.
REQ-026 Only one miss outstanding; no new acceptance in MISS, REFILL, RESP.
REQ-027 data_ok SHALL be 0 in IDLE, MISS, REFILL; rdata undefined when data_ok=0.

Reset
REQ-028 Reset SHALL force IDLE, clear all 256 valid bits, clear beat counter, and drive addr_ok=0, data_ok=0, rd_req=0 in the following cycle; rdata, data and tag arrays unreset.
REQ-029 Reset during MISS/REFILL SHALL abandon the refill, write no valid bit; memory side is reset concurrently.

Configuration
REQ-030 Macro ICACHE_PERF_CNT_EN: when defined, SHALL add outputs hit_cnt  out  32 and miss_cnt  out  32, reset to 0, incremented once per cached LOOKUP hit / cached miss respectively, wrapping at 2^32; when undefined, ports and counters SHALL be absent, behaviour otherwise identical.

Verification
REQ-031 After reset, req tag=0x1FC00 index=0x00 offset=0x4 cached -> rd_req line addr 0x1FC00000; beats 0x11,0x22,0x33,0x44 -> one data_ok, rdata=0x22 one cycle after last beat.
REQ-032 Repeat same address, then offset 0xC back-to-back -> addr_ok both consecutive cycles, data_ok in cycles 2 and 3, rdata 0x22 then 0x44, no rd_req.
REQ-033 Uncached req tag=0x1FD00 index=0x10 offset=0x8 -> rd_type=0, rd_addr=0x1FD00108, single beat 0xDEADBEEF -> rdata 0xDEADBEEF; repeat -> miss again.
REQ-034 Same index 0x00, tag 0x00400 -> miss, line replaced; then tag 0x1FC00 -> miss again.
REQ-035 Reset asserted after second refill beat -> no data_ok, next request to that line misses.
REQ-036 With ICACHE_PERF_CNT_EN, after REQ-031..032 sequence -> hit_cnt=2, miss_cnt=1.
